// File: rtl/blinkt_spi_shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : blinkt_pkg
//  Description : Shared types and constants for the Blinkt LED-bar SPI
//                shifter (FSM state encoding, LED frame constants).
//  Revision    : 1.0 - initial release
// ============================================================================
package blinkt_pkg;

    // Shifter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } blinkt_state_e;

    localparam int          LED_WORD_W  = 32;
    localparam int          LED_COUNT   = 8;
    localparam logic [31:0] START_FRAME = 32'h0000_0000;
    localparam logic [31:0] END_FRAME   = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/blinkt_spi_shifter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : blinkt_spi_shifter_if
//  Description : AXI-Stream style word input (data/valid/ready) feeding the
//                Blinkt SPI shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface blinkt_spi_shifter_if
    import blinkt_pkg::*;
#(
    parameter int WORD_W = LED_WORD_W
);
    logic [WORD_W-1:0] s_axis_data;
    logic              s_axis_valid;
    logic              s_axis_ready;

    modport master (
        output s_axis_data,
        output s_axis_valid,
        input  s_axis_ready
    );

    modport slave (
        input  s_axis_data,
        input  s_axis_valid,
        output s_axis_ready
    );
endinterface
`default_nettype wire

// File: rtl/blinkt_spi_shifter_sck_div.sv
`default_nettype none
// ============================================================================
//  Module      : blinkt_sck_div
//  Description : SCK half-period tick generator. While enabled, o_tick pulses
//                for one i_clk cycle every CLK_DIV cycles; the count restarts
//                from zero whenever the enable drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module blinkt_sck_div
    import blinkt_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_en,
    output logic      o_tick
);

    localparam int               CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == TERM);

    // Count up while enabled; clear on each tick so the count never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (!i_en || o_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/blinkt_spi_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : blinkt_spi_shifter
//  Description : Serialises stream words onto the Blinkt LED bar in SPI
//                mode 0, MSB first. FSM IDLE -> LOW -> HIGH ... -> DONE.
//                All outputs are registered, so they trail the FSM state by
//                one i_clk cycle.
//  Options     : `define BLINKT_SPI_SKID_EN adds a one-word holding register
//                so consecutive words stream with a continuous SCK.
//  Revision    : 1.0 - initial release
// ============================================================================
module blinkt_spi_shifter
    import blinkt_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = LED_WORD_W
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst_n,
    blinkt_spi_shifter_if.slave  axis,
    output logic                 o_sck,
    output logic                 o_sdo,
    output logic                 o_busy,
    output logic                 o_word_done
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOW  = ST_LOW;
    localparam logic [1:0] S_HIGH = ST_HIGH;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam int                BCNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(WORD_W - 1);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
    logic              ready_q, ready_d;
    logic              sdo_q,   sdo_d;
    logic              sck_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              tick;
    logic              div_en;

`ifdef BLINKT_SPI_SKID_EN
    logic [WORD_W-1:0] hold_q,      hold_d;
    logic              hold_full_q, hold_full_d;
    // chain_q marks a DONE cycle that already carries the next word's first
    // LOW cycle (shift register reloaded from the holding register).
    logic              chain_q,     chain_d;
`endif

    assign accept = axis.s_axis_valid && ready_q;

`ifdef BLINKT_SPI_SKID_EN
    assign div_en = (state_q == S_LOW) || (state_q == S_HIGH) ||
                    ((state_q == S_DONE) && chain_q);
`else
    assign div_en = (state_q == S_LOW) || (state_q == S_HIGH);
`endif

    blinkt_sck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (div_en),
        .o_tick  (tick)
    );

    // Next-state, shift register, bit counter and ready computation
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
`ifdef BLINKT_SPI_SKID_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        chain_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOW;
                    shreg_d = axis.s_axis_data;
                    bcnt_d  = BCNT_LOAD;
                end
            end
            S_LOW: begin
                if (tick) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    if (bcnt_q != '0) begin
                        state_d = S_LOW;
                        bcnt_d  = bcnt_q - 1'b1;
                        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    end else begin
                        state_d = S_DONE;
`ifdef BLINKT_SPI_SKID_EN
                        // Reload one cycle early so DONE doubles as the first
                        // LOW cycle of the next word and SCK stays periodic.
                        if (hold_full_q) begin
                            shreg_d     = hold_q;
                            bcnt_d      = BCNT_LOAD;
                            hold_full_d = 1'b0;
                            chain_d     = 1'b1;
                        end
`endif
                    end
                end
            end
            S_DONE: begin
`ifdef BLINKT_SPI_SKID_EN
                if (chain_q) begin
                    // With CLK_DIV=1 the DONE cycle was the whole LOW phase
                    state_d = tick ? S_HIGH : S_LOW;
                end else if (hold_full_q) begin
                    state_d     = S_LOW;
                    shreg_d     = hold_q;
                    bcnt_d      = BCNT_LOAD;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    state_d = S_LOW;
                    shreg_d = axis.s_axis_data;
                    bcnt_d  = BCNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef BLINKT_SPI_SKID_EN
        // Park the accepted word unless it went straight into the shifter
        if (accept && (state_q != S_IDLE) &&
            !((state_q == S_DONE) && !chain_q && !hold_full_q)) begin
            hold_d      = axis.s_axis_data;
            hold_full_d = 1'b1;
        end
        ready_d = !hold_full_d;
`else
        // Ready only in IDLE, and not on the cycle straight after DONE
        ready_d = (state_q == S_IDLE) && !accept;
`endif

        // SDO only moves while SCK is low; it parks at 0 in IDLE
        sdo_d = sdo_q;
        if (state_q == S_IDLE) begin
            sdo_d = 1'b0;
        end else if (state_q != S_HIGH) begin
            sdo_d = shreg_q[WORD_W-1];
        end
    end

    // FSM, datapath and registered outputs; reset aborts any word in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            ready_q <= 1'b0;
            sdo_q   <= 1'b0;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            ready_q <= ready_d;
            sdo_q   <= sdo_d;
            sck_q   <= (state_q == S_HIGH);
            busy_q  <= (state_q != S_IDLE);
            done_q  <= (state_q == S_DONE);
        end
    end

`ifdef BLINKT_SPI_SKID_EN
    // Holding register for the next word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            chain_q     <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            chain_q     <= chain_d;
        end
    end
`endif

    assign axis.s_axis_ready = ready_q;
    assign o_sck             = sck_q;
    assign o_sdo             = sdo_q;
    assign o_busy            = busy_q;
    assign o_word_done       = done_q;

endmodule
`default_nettype wire

// File: doc/blinkt_spi_shifter.md
BLINKT_SPI_SHIFTER -- requirements
Module: blinkt_spi_shifter

Interface
REQ-001 The block SHALL have a parameter CLK_DIV, default 4, giving the number of i_clk cycles per SCK half-period (legal range 1..255).
REQ-002 The block SHALL have a parameter WORD_W, default 32, giving the bits per stream word.
REQ-003 Port i_clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 Port i_rst_n  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-005 Port s_axis_data  input  WORD_W  SHALL carry the LED word (start frame, per-LED word, end frame).
REQ-006 Port s_axis_valid  input  1  SHALL signal that the upstream word is valid.
REQ-007 Port s_axis_ready  output  1  SHALL signal that the block can accept a word.
REQ-008 Port o_sck  output  1  SHALL drive the LED-bar serial clock.
REQ-009 Port o_sdo  output  1  SHALL drive the LED-bar serial data.
REQ-010 Port o_busy  output  1  SHALL be high while a word is shifting.
REQ-011 Port o_word_done  output  1  SHALL give a one-cycle pulse per completed word.

Function
REQ-012 A word SHALL be accepted on any rising edge where s_axis_valid and s_axis_ready are both high; s_axis_valid may be a single-cycle pulse.
REQ-013 s_axis_ready SHALL be level-held high in IDLE until acceptance, so a producer that samples ready and raises valid one cycle later is never lost.
REQ-014 The FSM SHALL have states IDLE, LOW (SCK low phase), HIGH (SCK high phase) and DONE.
REQ-015 IDLE SHALL go to LOW on accept, loading the shift register and setting the bit counter to WORD_W-1.
REQ-016 LOW SHALL go to HIGH after CLK_DIV cycles.
REQ-017 HIGH SHALL go to LOW after CLK_DIV cycles when the bit counter is nonzero, decrementing the counter and shifting left.
REQ-018 HIGH SHALL go to DONE after CLK_DIV cycles when the bit counter is zero.
REQ-019 DONE SHALL last one cycle, pulse o_word_done and return to IDLE.
REQ-020 Shifting SHALL be MSB first in SPI mode 0: o_sdo changes only in LOW, and o_sck is 1 only in HIGH.
REQ-021 Latency SHALL be as follows, for a word accepted at edge T:
- o_sdo equals bit WORD_W-1 from T+1;
- the first o_sck rise is at T+1+CLK_DIV;
- o_word_done is at T+1+2*CLK_DIV*WORD_W;
- s_axis_ready is high again the cycle after that.
REQ-022 o_busy SHALL be high in LOW, HIGH and DONE.
REQ-023 s_axis_ready SHALL be low outside IDLE, unless BLINKT_SPI_SKID_EN is defined.
REQ-024 The divider counter SHALL be $clog2(CLK_DIV+1) bits wide and the bit counter $clog2(WORD_W) bits wide; neither SHALL wrap mid-phase.
REQ-025 o_sdo SHALL return to 0 in IDLE; o_sck SHALL idle at 0.
REQ-026 With CLK_DIV=1, each bit SHALL take exactly 2 cycles.

Reset
REQ-027 While i_rst_n is low, all outputs SHALL take their reset values:
- state IDLE;
- o_sck=0, o_sdo=0, o_busy=0, o_word_done=0;
- s_axis_ready=0;
- counters and shift register 0.
REQ-028 s_axis_ready SHALL rise on the first i_clk edge after i_rst_n deasserts.
REQ-029 A reset asserted mid-word SHALL abort the word immediately (o_sck forced to 0 asynchronously); no o_word_done SHALL follow.

Configuration
REQ-030 With BLINKT_SPI_SKID_EN defined, the block SHALL add a one-word holding register, and s_axis_ready SHALL be high whenever that register is empty, including during LOW and HIGH.
REQ-031 With BLINKT_SPI_SKID_EN defined, DONE SHALL go directly to LOW when the holding register is full, giving zero idle cycles between words.
REQ-032 With BLINKT_SPI_SKID_EN defined, a word accepted in the DONE cycle itself SHALL be loaded without loss.
REQ-033 Without BLINKT_SPI_SKID_EN, the block SHALL have no holding register, and each word SHALL be followed by at least one IDLE cycle.

Structure
REQ-034 Package blinkt_pkg SHALL hold:
- the FSM state enum;
- LED_WORD_W=32;
- LED_COUNT=8;
- START_FRAME=32'h0000_0000;
- END_FRAME=32'hFFFF_FFFF.
REQ-035 The half-period tick generator SHALL be a separate sub-module, blinkt_sck_div (enable in, tick out, CLK_DIV parameter).

Verification
REQ-036 CLK_DIV=2, send 32'hA5000001 with a one-cycle valid -> o_sdo samples at 32 o_sck rises read 0xA5000001 MSB first; o_word_done is at T+129.
REQ-037 Full frame: 0x00000000, eight words 0xE0000001..0xE0000008, then 0xFFFFFFFF -> a 320-bit capture matches exactly; 10 o_word_done pulses.
REQ-038 Valid raised one cycle after ready is sampled, and held one cycle -> the word is accepted; ready stays high until acceptance.
REQ-039 Reset asserted at bit 17 -> o_sck=0 and o_sdo=0 asynchronously; no o_word_done; the next word after release shifts correctly.
REQ-040 BLINKT_SPI_SKID_EN with two back-to-back words -> o_sck is continuous across the word boundary; the second o_word_done is exactly 2*CLK_DIV*32 cycles after the first.
REQ-041 CLK_DIV=1 with 32'h80000000 -> o_sdo is 1 for the first 2 cycles, then 0; o_word_done is at T+65.
